// File: rtl/shift_seq_gen.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq_gen
// Description : Parametrised shift-sequence generator. Produces a Johnson,
//               ring or maximal-length LFSR sequence with enable, direction,
//               synchronous clear and parallel load. A state that is illegal
//               for the current mode is replaced by that mode's seed on the
//               next edge and flagged with a one-cycle o_err pulse.
// Ports       : i_clk       - clock, rising edge
//               i_arst_n    - asynchronous active-low reset
//               i_en        - advance one step
//               i_dir       - 0 = toward MSB, 1 = toward LSB (not LFSR)
//               i_mode      - 0 Johnson, 1 ring, 2 LFSR, 3 Johnson
//               i_sclr      - synchronous clear to the mode seed
//               i_load      - synchronous parallel load of i_load_val
//               i_load_val  - value for parallel load
//               o_q         - registered state
//               o_wrap      - pulse: an enabled step landed on the seed
//               o_err       - pulse: an illegal state was replaced by the seed
// Revision    : 1.0 - initial release
// ============================================================================
module shift_seq_gen #(
   parameter int                 WIDTH = 4,
   parameter logic [WIDTH-1:0]   TAPS  = WIDTH'(4'b1100)
) (
   input  logic               i_clk,
   input  logic               i_arst_n,
   input  logic               i_en,
   input  logic               i_dir,
   input  logic [1:0]         i_mode,
   input  logic               i_sclr,
   input  logic               i_load,
   input  logic [WIDTH-1:0]   i_load_val,
   output logic [WIDTH-1:0]   o_q,
   output logic               o_wrap,
   output logic               o_err
);

   localparam logic [1:0] c_MODE_JOHNSON = 2'd0;
   localparam logic [1:0] c_MODE_RING    = 2'd1;
   localparam logic [1:0] c_MODE_LFSR    = 2'd2;

   logic [WIDTH-1:0] r_q;
   logic             r_wrap;
   logic             r_err;
   logic             r_seeded;

   logic [WIDTH-1:0] w_seed;
   logic [WIDTH-1:0] w_step;
   logic             w_legal;
   logic [WIDTH-1:0] w_q_nxt;
   logic             w_wrap_nxt;
   logic             w_err_nxt;

   // Reserved mode 3 falls into the Johnson default in every function below.
   function automatic logic [WIDTH-1:0] f_seed(input logic [1:0] mode);
      logic [WIDTH-1:0] s;
      case (mode)
         c_MODE_RING: s = WIDTH'(1);
         c_MODE_LFSR: s = '1;
         default:     s = '0;
      endcase
      return s;
   endfunction

   function automatic logic [WIDTH-1:0] f_next(input logic [WIDTH-1:0] q,
                                               input logic [1:0]       mode,
                                               input logic             dir);
      logic [WIDTH-1:0] n;
      case (mode)
         c_MODE_RING: n = dir ? {q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], q[WIDTH-1]};
         c_MODE_LFSR: n = {q[WIDTH-2:0], ^(q & TAPS)};
         default:     n = dir ? {~q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], ~q[WIDTH-1]};
      endcase
      return n;
   endfunction

   // Johnson states are thermometer codes: at most one boundary between
   // adjacent differing bits. Ring states are one-hot (nonzero power of two).
   function automatic logic f_legal(input logic [WIDTH-1:0] q,
                                    input logic [1:0]       mode);
      logic ok;
      int   edges;
      edges = 0;
      for (int i = 0; i < WIDTH - 1; i++) begin
         if (q[i] != q[i+1]) edges++;
      end
      case (mode)
         c_MODE_RING: ok = (q != '0) && ((q & (q - WIDTH'(1))) == '0);
         c_MODE_LFSR: ok = (q != '0);
         default:     ok = (edges <= 1);
      endcase
      return ok;
   endfunction

   always_comb begin
      w_seed     = f_seed(i_mode);
      w_step     = f_next(r_q, i_mode, i_dir);
      w_legal    = f_legal(r_q, i_mode);
      w_q_nxt    = r_q;
      w_wrap_nxt = 1'b0;
      w_err_nxt  = 1'b0;
      if (!r_seeded) begin
         // First edge after reset release always seeds, silently.
         w_q_nxt = w_seed;
      end else if (i_sclr) begin
         w_q_nxt = w_seed;
      end else if (i_load) begin
         // Loaded unchecked; an illegal value is caught on the next edge.
         w_q_nxt = i_load_val;
      end else if (!w_legal) begin
         w_q_nxt   = w_seed;
         w_err_nxt = 1'b1;
      end else if (i_en) begin
         w_q_nxt    = w_step;
         w_wrap_nxt = (w_step == w_seed);
      end
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         r_q      <= '0;
         r_wrap   <= 1'b0;
         r_err    <= 1'b0;
         r_seeded <= 1'b0;
      end else begin
         r_q      <= w_q_nxt;
         r_wrap   <= w_wrap_nxt;
         r_err    <= w_err_nxt;
         r_seeded <= 1'b1;
      end
   end

   assign o_q    = r_q;
   assign o_wrap = r_wrap;
   assign o_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_shift_seq_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_seq_gen
// Description : Self-checking bench for shift_seq_gen (WIDTH = 4, default
//               TAPS). Directed vector table, hand-written corner sequences
//               and randomized stimulus against a sequence-list model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_seq_gen;

   localparam int         W    = 4;
   localparam int         MASK = (1 << W) - 1;
   localparam logic [3:0] TP   = 4'b1100;

   logic         clk;
   logic         rst_n;
   logic         en;
   logic         dir;
   logic [1:0]   mode;
   logic         sclr;
   logic         load;
   logic [W-1:0] load_val;
   logic [W-1:0] q;
   logic         wrap;
   logic         err;

   int n_checks = 0;
   int n_errors = 0;

   shift_seq_gen #(.WIDTH(W), .TAPS(TP)) dut (
      .i_clk      (clk),
      .i_arst_n   (rst_n),
      .i_en       (en),
      .i_dir      (dir),
      .i_mode     (mode),
      .i_sclr     (sclr),
      .i_load     (load),
      .i_load_val (load_val),
      .o_q        (q),
      .o_wrap     (wrap),
      .o_err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Johnson and ring modes are modelled as a list of legal states in
   // sequence order; stepping moves the index forward or backward.
   function automatic int seq_len(input int m);
      return (m == 1) ? W : 2 * W;
   endfunction

   function automatic int seq_val(input int m, input int k);
      if (m == 1) return 1 << k;
      if (k <= W) return (1 << k) - 1;
      return MASK & ~((1 << (k - W)) - 1);
   endfunction

   function automatic int seq_idx(input int m, input int v);
      for (int k = 0; k < seq_len(m); k++)
         if (seq_val(m, k) == v) return k;
      return -1;
   endfunction

   function automatic int m_seed(input int m);
      if (m == 2) return MASK;
      if (m == 1) return 1;
      return 0;
   endfunction

   function automatic bit m_legal(input int m, input int v);
      if (m == 2) return v != 0;
      return seq_idx(m, v) >= 0;
   endfunction

   function automatic int m_next(input int m, input int d, input int v);
      int p, fb;
      if (m == 2) begin
         fb = $countones(v & int'(TP)) % 2;
         return ((v * 2) & MASK) + fb;
      end
      p = seq_len(m);
      return seq_val(m, (seq_idx(m, v) + (d != 0 ? p - 1 : 1)) % p);
   endfunction

   int mq, mw, me, ms;
   always @(posedge clk or negedge rst_n) begin
      int md, nx;
      if (!rst_n) begin
         mq = 0; mw = 0; me = 0; ms = 0;
      end else begin
         md = (int'(mode) == 3) ? 0 : int'(mode);
         mw = 0; me = 0;
         if (ms == 0)                 mq = m_seed(md);
         else if (sclr)               mq = m_seed(md);
         else if (load)               mq = int'(load_val);
         else if (!m_legal(md, mq)) begin
            mq = m_seed(md); me = 1;
         end else if (en) begin
            nx = m_next(md, int'(dir), mq);
            mw = (nx == m_seed(md)) ? 1 : 0;
            mq = nx;
         end
         ms = 1;
      end
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic e, input logic d, input logic [1:0] m,
                        input logic s, input logic l, input logic [W-1:0] lv);
      en = e; dir = d; mode = m; sclr = s; load = l; load_val = lv;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       en;
      logic       dir;
      logic [1:0] mode;
      logic       sclr;
      logic       load;
      logic [3:0] lv;
      logic [3:0] exp_q;
      logic       exp_wrap;
      logic       exp_err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic e, input logic d, input logic [1:0] m,
                               input logic s, input logic l, input logic [3:0] lv,
                               input logic [3:0] eq, input logic ew, input logic ee);
      vec_t v;
      v.en = e; v.dir = d; v.mode = m; v.sclr = s; v.load = l; v.lv = lv;
      v.exp_q = eq; v.exp_wrap = ew; v.exp_err = ee;
      return v;
   endfunction

   initial begin
      logic [3:0] jup [8];
      logic [3:0] jdn [8];
      logic [3:0] lf  [7];
      int         steps;
      bit         done;

      jup = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
      jdn = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
      lf  = '{4'b1110, 4'b1100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1001};

      // Johnson up: seeding edge, then two full periods.
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
      for (int p = 0; p < 2; p++)
         for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(1, 0, 0, 0, 0, 0, jup[k % 8], k == 8, 0));
      // Johnson down from 0000.
      for (int k = 0; k < 8; k++)
         vecs.push_back(mk(1, 1, 0, 0, 0, 0, jdn[k], k == 7, 0));
      // Illegal load, correction, then normal stepping.
      vecs.push_back(mk(1, 0, 0, 0, 1, 4'b0101, 4'b0101, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0,       4'b0000, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0,       4'b0001, 0, 0));
      // Clear beats load beats enable.
      vecs.push_back(mk(1, 0, 0, 1, 1, 4'b1111, 4'b0000, 0, 0));
      // 0000 is illegal for ring: corrected even with enable low.
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 4'b0001, 0, 1));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 4'b0010, 0, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 4'b0100, 0, 0));
      // Ring -> LFSR with 0100: legal, keeps stepping.
      vecs.push_back(mk(1, 0, 2, 0, 0, 0, 4'b1001, 0, 0));
      // LFSR -> ring with 1001: illegal.
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 4'b0001, 0, 1));
      // LFSR from 1111.
      vecs.push_back(mk(0, 0, 2, 0, 1, 4'b1111, 4'b1111, 0, 0));
      for (int k = 0; k < 7; k++)
         vecs.push_back(mk(1, 0, 2, 0, 0, 0, lf[k], 0, 0));

      // ---------------- reset state ----------------
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      check("reset_q", int'(q), 0);
      check("reset_wrap", int'(wrap), 0);
      check("reset_err", int'(err), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // ---------------- vector table ----------------
      foreach (vecs[i]) begin
         drive(vecs[i].en, vecs[i].dir, vecs[i].mode, vecs[i].sclr, vecs[i].load, vecs[i].lv);
         tick();
         check($sformatf("vec%0d_q", i), int'(q), int'(vecs[i].exp_q));
         check($sformatf("vec%0d_wrap", i), int'(wrap), int'(vecs[i].exp_wrap));
         check($sformatf("vec%0d_err", i), int'(err), int'(vecs[i].exp_err));
      end

      // ---------------- LFSR period: wrap after exactly 15 steps ----------------
      drive(1, 0, 2, 0, 0, 0);
      steps = 7;
      done  = 0;
      for (int k = 0; k < 20 && !done; k++) begin
         tick();
         steps++;
         check("lfsr_nonzero", int'(q != 0), 1);
         if (wrap) done = 1;
      end
      check("lfsr_wrap_seen", int'(done), 1);
      check("lfsr_period", steps, 15);
      check("lfsr_wrap_q", int'(q), 4'hF);

      // ---------------- asynchronous reset mid-period ----------------
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_q", int'(q), 0);
      check("arst_wrap", int'(wrap), 0);
      check("arst_err", int'(err), 0);

      // ---------------- ring after reset ----------------
      drive(1, 0, 1, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("ring_seed_q", int'(q), 4'b0001);
      check("ring_seed_err", int'(err), 0);
      check("ring_seed_wrap", int'(wrap), 0);
      tick(); check("ring_q1", int'(q), 4'b0010);
      tick(); check("ring_q2", int'(q), 4'b0100);
      tick(); check("ring_q3", int'(q), 4'b1000);
      tick(); check("ring_q4", int'(q), 4'b0001);
      check("ring_wrap", int'(wrap), 1);
      dir = 1'b1;
      tick(); check("ring_down_q", int'(q), 4'b1000);
      check("ring_down_wrap", int'(wrap), 0);

      // ---------------- randomized against the model ----------------
      for (int c = 0; c < 600; c++) begin
         logic [1:0] rm;
         rm = mode;
         if ($urandom_range(0, 15) == 0) rm = 2'($urandom_range(0, 3));
         drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rm,
               $urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0,
               4'($urandom_range(0, 15)));
         tick();
         check("rand_q", int'(q), mq);
         check("rand_wrap", int'(wrap), mw);
         check("rand_err", int'(err), me);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/shift_seq_gen.md
# shift_seq_gen

Parametrised shift-sequence generator: the multi-mode, WIDTH-generic successor to the fixed 4-bit Johnson counter. Produces a Johnson, ring, or maximal-length LFSR sequence with enable, direction, parallel load and synchronous clear. Detects illegal states and self-corrects them, flagging each correction. Used as a phase/strobe source and a cheap pseudo-random pattern source inside `top`-level datapaths.

## Interface
- `WIDTH`, 4: state width; legal range 3..32.
- `TAPS`, 4'b1100: LFSR feedback mask, WIDTH bits; bit k set means q[k] is XORed into the feedback. The default is x^4+x^3+1. The integrator must supply a maximal polynomial for other widths.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_arst_n`  in  1  reset, asynchronous assert, active-low.
- `i_en`  in  1  advance one step this cycle.
- `i_dir`  in  1  0 = shift toward MSB (up), 1 = toward LSB (down); ignored in LFSR mode.
- `i_mode`  in  2  0 = Johnson, 1 = ring, 2 = LFSR, 3 = reserved (behaves as Johnson).
- `i_sclr`  in  1  synchronous clear to the seed of the current mode.
- `i_load`  in  1  synchronous parallel load.
- `i_load_val`  in  WIDTH  value loaded on `i_load`.
- `o_q`  out  WIDTH  current state, registered.
- `o_wrap`  out  1  registered 1-cycle pulse: an enabled step landed on the seed.
- `o_err`  out  1  registered 1-cycle pulse: an illegal state was replaced by the seed.

## Operation
- **Seeds.**
  - Johnson: all-zeros.
  - Ring: LSB-only (…0001).
  - LFSR: all-ones.
- **Next-state functions** (W = WIDTH).
  - Johnson up: {q[W-2:0], ~q[W-1]}. Johnson down: {~q[0], q[W-1:1]}. Period 2W.
  - Ring up: {q[W-2:0], q[W-1]}. Ring down: {q[0], q[W-1:1]}. Period W.
  - LFSR: {q[W-2:0], ^(q & TAPS)}. Period 2^W-1 with maximal TAPS.
- **Legal sets.**
  - Johnson: the 2W thermometer-shaped states, i.e. 0…01…1 or 1…10…0, including all-zeros and all-ones.
  - Ring: exactly one bit set.
  - LFSR: any nonzero value.
- **Per-edge priority, highest first:**
  1. Post-reset seeding: q <= seed(i_mode). No error is flagged.
  2. `i_sclr`: q <= seed(i_mode).
  3. `i_load`: q <= `i_load_val`, loaded unchecked.
  4. Illegal check: if q is illegal for the current `i_mode`, q <= seed and `o_err` = 1.
  5. `i_en`: q <= next(q).
  6. Otherwise hold.
- **Post-reset seeding flag.** An internal `seeded` flag resets to 0 and is set on the first edge after reset release. That first edge always loads the seed of the sampled `i_mode`, overriding everything else.
- **`o_wrap`.** Asserted on the cycle after an edge where `i_en` stepped q and next(q) == seed. It is not asserted for clear, load, correction, or seeding.
- **Mode change.** `i_mode` is sampled every cycle. A mode change that makes q illegal is corrected on the next edge, with `o_err` asserted.
- **Loaded illegal values.** A loaded value that is illegal is corrected on the following edge, with `o_err` asserted.

## Timing
- **Reset.** While `i_arst_n` = 0: `o_q` = 0, `o_wrap` = 0, `o_err` = 0, `seeded` = 0. Release is synchronous to `i_clk` by the integrator's reset synchroniser.
- **Latency.** Every input action is visible on `o_q` one cycle after the sampling edge. `o_wrap` and `o_err` are coincident with the `o_q` value that caused them.
- **Pulse width.** `o_wrap` and `o_err` are high for exactly one cycle per event. Back-to-back events produce back-to-back pulses.
- **Reset mid-sequence.** Asserting `i_arst_n` = 0 mid-sequence zeroes all outputs immediately, without waiting for a clock edge. After release, the first edge reseeds.
- **Simultaneous `i_sclr` and `i_load`.** Clear wins; the load value is discarded.
- **`i_load` with `i_en`.** The load wins; no step happens that cycle.
- **Wrap-around.** The step from the last state back to the seed is a normal step and raises `o_wrap`. Holding `i_en` = 1 gives `o_wrap` once per period.

## Test plan
- **Johnson up.** Reset, then mode 0 with `i_en` = 1 and `i_dir` = 0, WIDTH = 4. Required: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000. `o_wrap` = 1 only alongside the final 0000, and then every 8 cycles.
- **Johnson down.** Mode 0, `i_dir` = 1, from 0000. Required: 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000.
- **Ring.** Reset with mode 1. Required: first edge gives 0001 with `o_err` = 0. With `i_en` held: 0010, 0100, 1000, 0001 (`o_wrap` = 1). Then switch to `i_dir` = 1; required: 1000 next.
- **LFSR.** Mode 2, TAPS = 1100. Required: from 1111 the sequence is 1110, 1100, 1000, 0001, 0010, 0100, 1001…; `o_wrap` returns at 1111 after exactly 15 steps; 0000 never appears.
- **Illegal load.** Load 0101 in mode 0. Required: `o_q` = 0101 for one cycle, then 0000 with `o_err` = 1 for one cycle, then normal stepping.
- **Mode change.** Mode change 1 → 2 while q = 0100: no error, continue as LFSR. Mode change 2 → 1 while q = 1001: next edge gives 0001 and `o_err` = 1.
- **Priority and reset.** `i_sclr` + `i_load` + `i_en` in the same cycle: required `o_q` = seed. Asserting `i_arst_n` = 0 mid-period: required all outputs 0 without a clock edge.
